// File: rtl/mac_accum.sv
// mac_accum: two-stage signed multiply-accumulate back end.
// Stage 1 registers the incoming 32-bit product after sign-extending it to
// W = 32+GUARD bits and optionally negating it. Stage 2 adds that term into
// a W-bit accumulator.
// The accumulator drives a sticky wrap flag, a 32-bit saturated view, a
// saturating accumulation count, and a registered 16-bit read port.
module mac_accum #(
    parameter int GUARD = 8
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic [31:0] prod,
    input  logic        prod_valid,
    input  logic        sub,
    input  logic        clr,
    input  logic        rd,
    input  logic [1:0]  rd_sel,
    output logic [15:0] dout,
    output logic        ovf,
    output logic        sat,
    output logic        busy
);

    localparam int W = 32 + GUARD;

    // Stage 1 input term and register
    logic [W-1:0] prod_ext;
    logic [W-1:0] prod_term;
    logic         s1_valid;
    logic [W-1:0] s1_term;

    // Accumulator state and next-value terms
    logic [W-1:0] acc;
    logic [W-1:0] acc_sum;
    logic         add_ovf;
    logic [15:0]  count;

    // Saturated view and read path
    logic         above;
    logic         below;
    logic [31:0]  sat32;
    logic [15:0]  upper16;
    logic [15:0]  hold;
    logic [15:0]  rd_data;

    // Extend to W bits first, then negate, so -(-2^31) is exactly +2^31
    always_comb begin
        prod_ext  = {{GUARD{prod[31]}}, prod};
        prod_term = prod_ext;
        if (sub) begin
            prod_term = -prod_ext;
        end
    end

    // Stage 1: capture every strobe. A strobe in the clr cycle is still
    // captured here; the older entry is dropped by the accumulator stage.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            s1_valid <= 1'b0;
            s1_term  <= '0;
        end else begin
            s1_valid <= prod_valid;
            if (prod_valid) begin
                s1_term <= prod_term;
            end
        end
    end

    // W-bit signed add; overflow when both operands share a sign the sum lacks
    always_comb begin
        acc_sum = acc + s1_term;
        add_ovf = (acc[W-1] == s1_term[W-1]) && (acc_sum[W-1] != acc[W-1]);
    end

    // Stage 2: accumulate, count and flag wraps; clr wins over a pending add
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            acc   <= '0;
            count <= 16'h0000;
            ovf   <= 1'b0;
        end else if (clr) begin
            acc   <= '0;
            count <= 16'h0000;
            ovf   <= 1'b0;
        end else if (s1_valid) begin
            acc <= acc_sum;
            ovf <= ovf | add_ovf;
            if (count != 16'hFFFF) begin
                count <= count + 16'd1;
            end
        end
    end

    // Clamp the accumulator to the signed 32-bit range.
    // Bits W-1..31 must all agree for the value to fit in 32 bits.
    always_comb begin
        above   = !acc[W-1] && (|acc[W-2:31]);
        below   = acc[W-1] && !(&acc[W-2:31]);
        sat32   = acc[31:0];
        if (above) begin
            sat32 = 32'h7FFF_FFFF;
        end else if (below) begin
            sat32 = 32'h8000_0000;
        end
        upper16 = 16'($signed(acc[W-1:32]));
    end

    // Read slice select, always from the pre-update accumulator
    always_comb begin
        rd_data = 16'h0000;
        case (rd_sel)
            2'd0:    rd_data = sat32[15:0];
            2'd1:    rd_data = hold;
            2'd2:    rd_data = upper16;
            default: rd_data = count;
        endcase
    end

    // Registered read port. Slice 0 also captures the upper half into hold.
    // dout keeps its value when rd is low.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            dout <= 16'h0000;
            hold <= 16'h0000;
        end else begin
            if (rd) begin
                dout <= rd_data;
            end
            if (clr) begin
                hold <= 16'h0000;
            end else if (rd && (rd_sel == 2'd0)) begin
                hold <= sat32[31:16];
            end
        end
    end

    // Status outputs
    always_comb begin
        sat  = above | below;
        busy = s1_valid | prod_valid;
    end

endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum. Two instances are driven in parallel from the same
// inputs: one with GUARD=8 and one with GUARD=1.
// The reference model keeps each accumulator as a 64-bit integer, wraps it
// arithmetically to the instance width and clamps it for reads.
module tb_mac_accum;

    localparam longint MAXP = 64'sd2147483647;
    localparam longint MINN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        resetq = 1'b1;
    logic [31:0] prod = '0;
    logic        prod_valid = 1'b0;
    logic        sub = 1'b0;
    logic        clr = 1'b0;
    logic        rd = 1'b0;
    logic [1:0]  rd_sel = 2'd0;

    logic [15:0] dout0, dout1;
    logic        ovf0, ovf1, sat0, sat1, busy0, busy1;

    // Reference model state, index 0 = GUARD 8, index 1 = GUARD 1
    int          gw[2] = '{40, 33};
    longint      m_acc[2];
    int          m_cnt[2];
    logic        m_ovf[2];
    logic [15:0] m_hold[2];
    logic [15:0] m_dout[2];
    logic        pend_v;
    logic        pend_sub;
    logic [31:0] pend_prod;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mac_accum #(.GUARD(8)) dut0 (
        .clk(clk), .resetq(resetq), .prod(prod), .prod_valid(prod_valid),
        .sub(sub), .clr(clr), .rd(rd), .rd_sel(rd_sel),
        .dout(dout0), .ovf(ovf0), .sat(sat0), .busy(busy0)
    );

    mac_accum #(.GUARD(1)) dut1 (
        .clk(clk), .resetq(resetq), .prod(prod), .prod_valid(prod_valid),
        .sub(sub), .clr(clr), .rd(rd), .rd_sel(rd_sel),
        .dout(dout1), .ovf(ovf1), .sat(sat1), .busy(busy1)
    );

    function automatic longint wrapw(longint x, int w);
        int s;
        s = 64 - w;
        return (x <<< s) >>> s;
    endfunction

    function automatic logic [31:0] clamp32(longint a);
        if (a > MAXP) return 32'h7FFF_FFFF;
        if (a < MINN) return 32'h8000_0000;
        return a[31:0];
    endfunction

    function automatic logic m_sat(int i);
        return (m_acc[i] > MAXP) || (m_acc[i] < MINN);
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_acc[i]  = 0;
            m_cnt[i]  = 0;
            m_ovf[i]  = 1'b0;
            m_hold[i] = 16'h0000;
            m_dout[i] = 16'h0000;
        end
        pend_v = 1'b0;
        pend_sub = 1'b0;
        pend_prod = '0;
    endtask

    // One clock edge of the reference behaviour.
    // A read sees the old value. clr clears the result and drops the
    // product from the previous cycle. This cycle's product becomes pending.
    task automatic model_edge(logic v, logic sb, logic [31:0] p, logic c,
                              logic r, logic [1:0] sel);
        longint val, full, nxt;
        logic [31:0] s32;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                s32 = clamp32(m_acc[i]);
                case (sel)
                    2'd0: begin
                        m_dout[i] = s32[15:0];
                        m_hold[i] = s32[31:16];
                    end
                    2'd1: m_dout[i] = m_hold[i];
                    2'd2: m_dout[i] = 16'(m_acc[i] >>> 32);
                    default: m_dout[i] = 16'(m_cnt[i]);
                endcase
            end
            if (c) begin
                m_acc[i]  = 0;
                m_cnt[i]  = 0;
                m_ovf[i]  = 1'b0;
                m_hold[i] = 16'h0000;
            end else if (pend_v) begin
                val  = longint'($signed(pend_prod));
                if (pend_sub) val = -val;
                full = m_acc[i] + val;
                nxt  = wrapw(full, gw[i]);
                if (nxt != full) m_ovf[i] = 1'b1;
                m_acc[i] = nxt;
                if (m_cnt[i] < 65535) m_cnt[i]++;
            end
        end
        pend_v    = v;
        pend_sub  = sb;
        pend_prod = p;
    endtask

    task automatic check_all(string tag);
        chk({tag, "_dout_g8"}, dout0, m_dout[0]);
        chk({tag, "_dout_g1"}, dout1, m_dout[1]);
        chk({tag, "_ovf_g8"}, 16'(ovf0), 16'(m_ovf[0]));
        chk({tag, "_ovf_g1"}, 16'(ovf1), 16'(m_ovf[1]));
        chk({tag, "_sat_g8"}, 16'(sat0), 16'(m_sat(0)));
        chk({tag, "_sat_g1"}, 16'(sat1), 16'(m_sat(1)));
        chk({tag, "_busy_g8"}, 16'(busy0), 16'(pend_v));
        chk({tag, "_busy_g1"}, 16'(busy1), 16'(pend_v));
    endtask

    // Drive one cycle of inputs, take the edge, then idle the inputs and check
    task automatic step(string tag, logic v, logic sb, logic [31:0] p,
                        logic c, logic r, logic [1:0] sel);
        prod_valid = v;
        sub        = sb;
        prod       = p;
        clr        = c;
        rd         = r;
        rd_sel     = sel;
        @(posedge clk);
        model_edge(v, sb, p, c, r, sel);
        #1;
        prod_valid = 1'b0;
        sub        = 1'b0;
        clr        = 1'b0;
        rd         = 1'b0;
        #1;
        check_all(tag);
    endtask

    task automatic idle(string tag);
        step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic add(string tag, logic sb, logic [31:0] p);
        step(tag, 1'b1, sb, p, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic read(string tag, logic [1:0] sel);
        step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, sel);
    endtask

    task automatic clear(string tag);
        step(tag, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 2'd0);
    endtask

    initial begin
        logic [31:0] rp;
        logic        rv, rs, rc, rr;
        logic [1:0]  rsel;

        // Reset state
        model_reset();
        #1 resetq = 1'b0;
        #2;
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        resetq = 1'b1;
        @(negedge clk);

        // Add 6, subtract -2, read in the cycle of the second accumulation
        add("a6", 1'b0, 32'h0000_0006);
        add("s_m2", 1'b1, 32'hFFFF_FFFE);
        read("rd_preupd", 2'd0);
        chk("r028_preupd_g8", dout0, 16'h0006);
        read("rd_sel0", 2'd0);
        chk("r028_sel0_g8", dout0, 16'h0008);
        chk("r028_sel0_g1", dout1, 16'h0008);
        read("rd_sel3", 2'd3);
        chk("r028_sel3_g8", dout0, 16'h0002);

        // Two maximal positive adds saturate the 32-bit view
        clear("clr1");
        add("max_a", 1'b0, 32'h7FFF_FFFF);
        add("max_b", 1'b0, 32'h7FFF_FFFF);
        idle("max_i0");
        idle("max_i1");
        chk("r029_sat_g8", 16'(sat0), 16'h0001);
        read("max_rd0", 2'd0);
        chk("r029_sel0_g8", dout0, 16'hFFFF);
        read("max_rd1", 2'd1);
        chk("r029_sel1_g8", dout0, 16'h7FFF);
        read("max_rd2", 2'd2);
        chk("r029_sel2_g8", dout0, 16'h0000);
        chk("r029_ovf_g8", 16'(ovf0), 16'h0000);
        chk("r029_ovf_g1", 16'(ovf1), 16'h0000);

        // Negating the most negative product gives +2^31
        clear("clr2");
        add("neg_min", 1'b1, 32'h8000_0000);
        idle("neg_i0");
        idle("neg_i1");
        chk("r030_sat_g8", 16'(sat0), 16'h0001);
        chk("r030_sat_g1", 16'(sat1), 16'h0001);
        read("neg_rd0", 2'd0);
        read("neg_rd1", 2'd1);
        chk("r030_hi_g8", dout0, 16'h7FFF);
        read("neg_rd2", 2'd2);
        chk("r030_sel2_g8", dout0, 16'h0000);

        // GUARD=1 wrap: 2^32-2 plus 2^31-1 wraps, flag sticks until clr
        clear("clr3");
        add("w_a", 1'b0, 32'h7FFF_FFFF);
        add("w_b", 1'b0, 32'h7FFF_FFFF);
        add("w_c", 1'b0, 32'h7FFF_FFFF);
        idle("w_i0");
        chk("r031_ovf_g1", 16'(ovf1), 16'h0001);
        chk("r031_ovf_g8", 16'(ovf0), 16'h0000);
        add("w_d", 1'b0, 32'h0000_0005);
        add("w_e", 1'b1, 32'h0000_0100);
        idle("w_i1");
        idle("w_i2");
        chk("r031_sticky_g1", 16'(ovf1), 16'h0001);
        clear("clr4");
        chk("r031_clr_g1", 16'(ovf1), 16'h0000);

        // clr with a new strobe in the same cycle kills the older S1 entry
        add("k_old", 1'b0, 32'h0000_0100);
        step("k_clr", 1'b1, 1'b0, 32'h0000_0005, 1'b1, 1'b0, 2'd0);
        idle("k_i0");
        idle("k_i1");
        read("k_rd0", 2'd0);
        chk("r032_acc_g8", dout0, 16'h0005);
        read("k_rd3", 2'd3);
        chk("r032_cnt_g8", dout0, 16'h0001);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       rp = $urandom;
                1:       rp = 32'h7FFF_FFFF;
                2:       rp = 32'h8000_0000;
                default: rp = 32'($urandom_range(0, 255)) - 32'd128;
            endcase
            rv   = ($urandom_range(0, 3) != 0);
            rs   = 1'($urandom_range(0, 1));
            rc   = ($urandom_range(0, 31) == 0);
            rr   = ($urandom_range(0, 2) == 0);
            rsel = 2'($urandom_range(0, 3));
            step("rnd", rv, rs, rp, rc, rr, rsel);
        end

        // Reset pulse while a product is in flight
        read("pre_rst", 2'd3);
        add("inflight", 1'b0, 32'h0000_0040);
        chk("r033_busy_before", 16'(busy0), 16'h0001);
        resetq = 1'b0;
        model_reset();
        #1;
        check_all("mid_rst");
        chk("r033_dout_g8", dout0, 16'h0000);
        chk("r033_busy_g8", 16'(busy0), 16'h0000);
        @(negedge clk);
        @(negedge clk);
        resetq = 1'b1;
        @(negedge clk);
        add("post_a3", 1'b0, 32'h0000_0003);
        idle("post_i0");
        idle("post_i1");
        read("post_rd0", 2'd0);
        chk("r033_acc_g8", dout0, 16'h0003);
        chk("r033_acc_g1", dout1, 16'h0003);
        read("post_rd2", 2'd2);
        chk("r033_upper_g8", dout0, 16'h0000);
        read("post_rd3", 2'd3);
        chk("r033_cnt_g8", dout0, 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
